// File: rtl/uart_rx.sv
// uart_rx: receive half of the SoC UART.
//
// Receives asynchronous serial frames (idle high, start 0, 8 data bits LSB
// first, stop 1) and presents each good byte on a valid/read handshake.
// The line is double-flopped before use and every bit is sampled at its
// midpoint. Framing and overrun conditions are reported as sticky flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   Defined   -> 8-E-1 frames: a parity bit follows the data, and the
//                PARITY_ERR port is present.
//   Undefined -> 8-N-1 frames; no PARITY_ERR port.
//
// Parameters:
//   FREQ      system clock frequency in Hz
//   BAUDRATE  line rate in bit/s; DIV = FREQ / BAUDRATE clocks per bit (>= 4)
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   RX_Serial   serial line, asynchronous to clk, idle high
//   RX_READ     one-cycle pulse: consumer has taken RX_DATA
//   RX_DATA     last good byte received
//   RX_VALID    byte available; set on good stop bit, cleared by RX_READ
//   RX_BUSY     high whenever the receiver is not idle
//   FRAME_ERR   sticky: stop bit sampled low
//   PARITY_ERR  sticky: parity mismatch (only with UART_RX_PARITY_EN)
//   OVERRUN     sticky: good byte completed while RX_VALID was still set
module uart_rx #(
    parameter int unsigned FREQ     = 100000000,
    parameter int unsigned BAUDRATE = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RX_Serial,
    input  logic       RX_READ,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_BUSY,
    output logic       FRAME_ERR,
`ifdef UART_RX_PARITY_EN
    output logic       PARITY_ERR,
`endif
    output logic       OVERRUN
);

    localparam int unsigned DIV = FREQ / BAUDRATE;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
`endif

    logic          rx_meta_q, rx_sync_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          good_stop, bad_stop, read_ok;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d;
    logic          par_fail;
`endif

    // Receive FSM: all decisions use the synchronised line only.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_fail  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_sync_q) state_d = START;
            end
            START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    state_d = rx_sync_q ? IDLE : DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    sh_d  = {rx_sync_q, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = PARITY;
`else
                    if (idx_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    par_fail = (^sh_q) ^ rx_sync_q;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    good_stop = rx_sync_q;
                    bad_stop  = !rx_sync_q;
                    state_d   = rx_sync_q ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // A line held low must go high before a new frame can start.
                if (rx_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_d != state_q) || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Handshake and sticky flags. A completing byte overrides a same-cycle
    // read for VALID, but the read still suppresses OVERRUN.
    always_comb begin
        read_ok = RX_READ && valid_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (read_ok) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end
        if (good_stop) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            if (valid_q && !RX_READ) ovr_d = 1'b1;
        end
        if (bad_stop) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (par_fail) perr_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            sh_q      <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RX_Serial;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign RX_DATA    = data_q;
    assign RX_VALID   = valid_q;
    assign RX_BUSY    = (state_q != IDLE);
    assign FRAME_ERR  = ferr_q;
    assign OVERRUN    = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with FREQ=160, BAUDRATE=10
// (16 clocks per bit). Frames are driven bit by bit on the falling clock
// edge; a frame-level model predicts data and flags after every frame.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned FREQ     = 160;
    localparam int unsigned BAUDRATE = 10;
    localparam int unsigned DIV      = FREQ / BAUDRATE;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned BITS_AFTER_START = 10;  // 8 data + parity + stop
`else
    localparam int unsigned BITS_AFTER_START = 9;   // 8 data + stop
`endif
    // Clock edges from the start edge to RX_VALID visible: sync + half bit + rest.
    localparam int unsigned VALID_LAT = 3 + DIV / 2 + BITS_AFTER_START * DIV;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       RX_Serial;
    logic       RX_READ;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_BUSY;
    logic       FRAME_ERR;
    logic       OVERRUN;
`ifdef UART_RX_PARITY_EN
    logic       PARITY_ERR;
`endif

    uart_rx #(
        .FREQ     (FREQ),
        .BAUDRATE (BAUDRATE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .RX_Serial (RX_Serial),
        .RX_READ   (RX_READ),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_BUSY   (RX_BUSY),
        .FRAME_ERR (FRAME_ERR),
`ifdef UART_RX_PARITY_EN
        .PARITY_ERR(PARITY_ERR),
`endif
        .OVERRUN   (OVERRUN)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference state.
    logic [7:0] exp_data;
    logic       exp_valid, exp_ferr, exp_ovr, exp_perr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"},  32'(RX_DATA),   32'(exp_data));
        check({tag, ".valid"}, 32'(RX_VALID),  32'(exp_valid));
        check({tag, ".ferr"},  32'(FRAME_ERR), 32'(exp_ferr));
        check({tag, ".ovr"},   32'(OVERRUN),   32'(exp_ovr));
`ifdef UART_RX_PARITY_EN
        check({tag, ".perr"},  32'(PARITY_ERR), 32'(exp_perr));
`endif
    endtask

    task automatic model_reset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_perr  = 1'b0;
    endtask

    task automatic model_read();
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            exp_ovr   = 1'b0;
            exp_perr  = 1'b0;
        end
    endtask

    // Effect of one whole frame; read_at_end models a read landing on the
    // same cycle the stop bit is judged.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop,
                               input logic read_at_end);
`ifdef UART_RX_PARITY_EN
        if (((^b) ^ par) != 1'b0) exp_perr = 1'b1;
`endif
        if (read_at_end) model_read();
        if (stop) begin
            if (exp_valid) exp_ovr = 1'b1;
            exp_data  = b;
            exp_valid = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    // All stimulus tasks start and end on a falling clock edge.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        RX_Serial = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_Serial = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        RX_Serial = par;
        repeat (DIV) @(negedge clk);
`endif
        RX_Serial = stop;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        RX_Serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic read_pulse();
        RX_READ = 1'b1;
        @(negedge clk);
        RX_READ = 1'b0;
    endtask

    task automatic good_frame(input logic [7:0] b);
        send_frame(b, ^b, 1'b1);
        model_frame(b, ^b, 1'b1, 1'b0);
        idle(DIV);
    endtask

    int lat;

    initial begin
        RX_Serial = 1'b1;
        RX_READ   = 1'b0;
        reset_n   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset.busy", 32'(RX_BUSY), 32'd0);
        reset_n = 1'b1;
        idle(DIV);

        // 1: 0xA5 with latency measurement, then read.
        lat = 0;
        fork
            send_frame(8'hA5, ^8'hA5, 1'b1);
            begin
                while (lat < 400) begin
                    @(posedge clk);
                    lat++;
                    #1;
                    if (RX_VALID) break;
                end
            end
        join
        check("t1.latency", 32'(lat), 32'(VALID_LAT));
        model_frame(8'hA5, ^8'hA5, 1'b1, 1'b0);
        idle(DIV);
        check_outputs("t1");
        read_pulse();
        model_read();
        check_outputs("t1.read");

        // 2: short glitch on the idle line.
        RX_Serial = 1'b0;
        repeat (4) @(negedge clk);
        check("t2.busy_during", 32'(RX_BUSY), 32'd1);
        RX_Serial = 1'b1;
        for (int i = 0; i < 10 && RX_BUSY; i++) @(negedge clk);
        check("t2.busy_after", 32'(RX_BUSY), 32'd0);
        idle(2 * DIV);
        check_outputs("t2");

        // 3: bad stop, line held low, then a good frame.
        send_frame(8'h3C, ^8'h3C, 1'b0);
        model_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
        repeat (20 * DIV) @(negedge clk);
        check("t3.busy_break", 32'(RX_BUSY), 32'd1);
        check_outputs("t3.break");
        idle(DIV);
        check("t3.busy_idle", 32'(RX_BUSY), 32'd0);
        good_frame(8'h55);
        check_outputs("t3.next");
        read_pulse();
        model_read();
        check_outputs("t3.read");

        // 4: overrun.
        good_frame(8'h11);
        good_frame(8'h22);
        check_outputs("t4");
        read_pulse();
        model_read();
        check_outputs("t4.read");

        // Read landing on the stop-bit cycle: no overrun, new byte stays valid.
        good_frame(8'h33);
        fork
            send_frame(8'h44, ^8'h44, 1'b1);
            begin
                repeat (VALID_LAT - 1) @(posedge clk);
                #1 RX_READ = 1'b1;
                @(posedge clk);
                #1 RX_READ = 1'b0;
            end
        join
        model_frame(8'h44, ^8'h44, 1'b1, 1'b1);
        idle(DIV);
        check_outputs("same_cycle_read");
        read_pulse();
        model_read();

        // 5: reset mid-DATA of 0xFF, then 0x5A.
        good_frame(8'h99);
        fork
            send_frame(8'hFF, ^8'hFF, 1'b1);
            begin
                repeat (5 * DIV) @(posedge clk);
                #1 reset_n = 1'b0;
                model_reset();
                #1;
                check_outputs("t5.reset");
                check("t5.reset.busy", 32'(RX_BUSY), 32'd0);
                repeat (DIV) @(posedge clk);
                #1 reset_n = 1'b1;
            end
        join
        idle(DIV);
        check_outputs("t5.after");
        good_frame(8'h5A);
        check_outputs("t5.next");
        read_pulse();
        model_read();

`ifdef UART_RX_PARITY_EN
        // 6: parity good then bad.
        send_frame(8'h07, 1'b1, 1'b1);
        model_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(DIV);
        check_outputs("t6.good");
        read_pulse();
        model_read();
        send_frame(8'h07, 1'b0, 1'b1);
        model_frame(8'h07, 1'b0, 1'b1, 1'b0);
        idle(DIV);
        check_outputs("t6.bad");
        read_pulse();
        model_read();
`endif

        // Randomised frames with occasional bad stop/parity and optional reads.
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            logic       stop, par;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            par  = (^b) ^ ($urandom_range(0, 4) == 0);
            send_frame(b, par, stop);
            model_frame(b, par, stop, 1'b0);
            idle(DIV * $urandom_range(1, 2));
            check_outputs($sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                read_pulse();
                model_read();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
